mesh_terminal_rx: RTL and testbench

Synthesizable terminal-side receiver for one output port of the `mesh_gnrtr` router mesh. It consumes packets the router presents on `pndng`/`data_out` by pulsing `pop`, checks the destination address against its own terminal coordinates, and buffers accepted packets in a local first-word-fall-through FIFO. A downstream consumer drains that FIFO. The block is the hardware counterpart of the bench monitor, and one instance is placed per mesh terminal.

---
 rtl/mesh_terminal_rx.sv | 123 ++++++++++++
 tb/tb_mesh_terminal_rx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mesh_terminal_rx.sv
// Terminal-side receiver for one mesh router output port: pops router packets,
// filters them by destination address and buffers accepted ones in a FWFT FIFO.
module mesh_terminal_rx #(
  parameter int          PAKG_SIZE  = 32,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [3:0]  ROW_ID     = 4'd0,
  parameter logic [3:0]  COL_ID     = 4'd0,
  parameter logic [7:0]  BDCST      = 8'hFF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 pndng_i,
  input  logic [PAKG_SIZE-1:0] data_i,
  output logic                 pop_o,
  input  logic                 rd_en_i,
  output logic [PAKG_SIZE-1:0] rd_data_o,
  output logic                 empty_o,
  output logic                 full_o,
  output logic [15:0]          pkt_cnt_o,
  output logic [15:0]          err_cnt_o,
  output logic                 err_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_POP    = 2'd1,
    S_SETTLE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_capture;
  logic                 w_pop;
  logic                 w_accept;
  logic                 w_wr;
  logic                 w_rd;

  logic [PAKG_SIZE-1:0] r_cap;
  logic [PAKG_SIZE-1:0] r_last;
  logic [PAKG_SIZE-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [AW:0]          r_count;
  logic [15:0]          r_pkt_cnt;
  logic [15:0]          r_err_cnt;

  assign w_accept = ((r_cap[PAKG_SIZE-9 -: 4] == ROW_ID) && (r_cap[PAKG_SIZE-13 -: 4] == COL_ID))
                  || (r_cap[PAKG_SIZE-1 -: 8] == BDCST);

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (pndng_i && !full_o) begin
          w_capture   = 1'b1;
          w_state_nxt = S_POP;
        end
      end
      S_POP: begin
        w_pop       = 1'b1;
        w_state_nxt = S_SETTLE;
      end
      S_SETTLE: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_cap   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) r_cap <= data_i;
    end
  end

  // The write happens in POP only; full was checked in IDLE, so it cannot overflow.
  assign w_wr = w_pop & w_accept;
  assign w_rd = rd_en_i & (r_count != '0);

  always_ff @(posedge clk_i) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_cap;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_last    <= '0;
      r_pkt_cnt <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_last   <= r_cap;
        if (r_pkt_cnt != 16'hFFFF) r_pkt_cnt <= r_pkt_cnt + 1'b1;
      end
      if (w_pop && !w_accept && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign pop_o     = w_pop;
  assign err_o     = w_pop & ~w_accept;
  assign empty_o   = (r_count == '0);
  assign full_o    = (r_count == FULL_CNT);
  assign rd_data_o = empty_o ? r_last : r_mem[r_rd_ptr];
  assign pkt_cnt_o = r_pkt_cnt;
  assign err_cnt_o = r_err_cnt;

endmodule

// File: tb/tb_mesh_terminal_rx.sv
// Randomized bench for mesh_terminal_rx with a queue-based router/FIFO reference model.
module tb_mesh_terminal_rx;

  localparam int DEPTH = 16;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        pndng_i;
  logic [31:0] data_i;
  logic        pop_o;
  logic        rd_en_i;
  logic [31:0] rd_data_o;
  logic        empty_o;
  logic        full_o;
  logic [15:0] pkt_cnt_o;
  logic [15:0] err_cnt_o;
  logic        err_o;

  mesh_terminal_rx #(
    .PAKG_SIZE (32),
    .FIFO_DEPTH(DEPTH),
    .ROW_ID    (4'd2),
    .COL_ID    (4'd1),
    .BDCST     (8'hFF)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .pndng_i  (pndng_i),
    .data_i   (data_i),
    .pop_o    (pop_o),
    .rd_en_i  (rd_en_i),
    .rd_data_o(rd_data_o),
    .empty_o  (empty_o),
    .full_o   (full_o),
    .pkt_cnt_o(pkt_cnt_o),
    .err_cnt_o(err_cnt_o),
    .err_o    (err_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] rq[$];
  logic [31:0] mq[$];
  logic [31:0] m_last = '0;
  int          m_pkt = 0;
  int          m_err = 0;
  int          cyc = 0;
  int          last_pop = -10;
  int          n_pops = 0;
  int          n_errp = 0;
  int          stall = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit accepted(input logic [31:0] p);
    return ((p[23:20] == 4'd2) && (p[19:16] == 4'd1)) || (p[31:24] == 8'hFF);
  endfunction

  function automatic logic [31:0] mk_pkt(input bit good);
    logic [7:0] jmp;
    logic [3:0] row;
    logic [3:0] col;
    jmp = 8'($urandom_range(0, 254));
    row = 4'd2;
    col = 4'd1;
    if (!good) begin
      row = 4'($urandom_range(0, 15));
      col = 4'($urandom_range(0, 15));
      if (row == 4'd2 && col == 4'd1) col = 4'd5;
    end else if ($urandom_range(0, 3) == 0) begin
      jmp = 8'hFF;
      row = 4'($urandom_range(0, 15));
    end
    return {jmp, row, col, 16'($urandom)};
  endfunction

  task automatic drive_router();
    pndng_i = (rq.size() > 0);
    data_i  = (rq.size() > 0) ? rq[0] : 32'h0;
  endtask

  task automatic model_reset();
    mq.delete();
    m_last = '0;
    m_pkt  = 0;
    m_err  = 0;
  endtask

  // One clock: called and returns at a falling edge.
  task automatic step();
    logic        pop_s;
    logic        rd_s;
    logic [31:0] head;
    pop_s = pop_o;
    rd_s  = rd_en_i;
    head  = (rq.size() > 0) ? rq[0] : 32'h0;
    check_eq("err_o", 32'(err_o), 32'(pop_s && !accepted(head)));
    if (pop_s) begin
      check_eq("pop_has_pending", 32'(rq.size() > 0), 32'd1);
      check_eq("pop_spacing", 32'(cyc - last_pop >= 3), 32'd1);
      last_pop = cyc;
      n_pops++;
      if (!accepted(head)) n_errp++;
      stall = 0;
    end else if (rq.size() > 0 && mq.size() < DEPTH) begin
      stall++;
    end else begin
      stall = 0;
    end
    check_eq("no_stall", 32'(stall <= 5), 32'd1);
    @(posedge clk_i);
    cyc++;
    if (rd_s && mq.size() > 0) void'(mq.pop_front());
    if (pop_s && rq.size() > 0) begin
      void'(rq.pop_front());
      if (accepted(head)) begin
        check_eq("no_overflow", 32'(mq.size() < DEPTH), 32'd1);
        mq.push_back(head);
        m_last = head;
        if (m_pkt < 16'hFFFF) m_pkt++;
      end else if (m_err < 16'hFFFF) begin
        m_err++;
      end
    end
    @(negedge clk_i);
    check_eq("empty_o", 32'(empty_o), 32'(mq.size() == 0));
    check_eq("full_o", 32'(full_o), 32'(mq.size() == DEPTH));
    check_eq("rd_data_o", rd_data_o, (mq.size() > 0) ? mq[0] : m_last);
    check_eq("pkt_cnt_o", 32'(pkt_cnt_o), 32'(m_pkt));
    check_eq("err_cnt_o", 32'(err_cnt_o), 32'(m_err));
    drive_router();
  endtask

  initial begin
    int p0;
    rst_i   = 1'b0;
    rd_en_i = 1'b0;
    rq.push_back(32'h0021_0ABC);
    drive_router();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check_eq("rst_pop", 32'(pop_o), 32'd0);
    end
    check_eq("rst_empty", 32'(empty_o), 32'd1);
    check_eq("rst_full", 32'(full_o), 32'd0);
    check_eq("rst_rd_data", rd_data_o, 32'h0);
    check_eq("rst_pkt_cnt", 32'(pkt_cnt_o), 32'd0);
    check_eq("rst_err_cnt", 32'(err_cnt_o), 32'd0);
    check_eq("rst_err_o", 32'(err_o), 32'd0);
    rst_i = 1'b1;
    check_eq("release_no_pop", 32'(pop_o), 32'd0);
    step();
    check_eq("first_pop_edge2", 32'(pop_o), 32'd1);
    for (int i = 0; i < 4; i++) step();
    check_eq("pkt_addr_match", rd_data_o, 32'h0021_0ABC);
    check_eq("pkt_cnt_1", 32'(pkt_cnt_o), 32'd1);
    check_eq("no_err_pulse", 32'(n_errp), 32'd0);

    rd_en_i = 1'b1;
    step();
    rd_en_i = 1'b0;
    rq.push_back(32'h0033_0001);
    drive_router();
    for (int i = 0; i < 5; i++) step();
    check_eq("misroute_err_cnt", 32'(err_cnt_o), 32'd1);
    check_eq("misroute_empty", 32'(empty_o), 32'd1);
    check_eq("misroute_err_pulses", 32'(n_errp), 32'd1);

    rq.push_back(32'hFF33_1234);
    drive_router();
    for (int i = 0; i < 5; i++) step();
    check_eq("bcast_pkt_cnt", 32'(pkt_cnt_o), 32'd2);
    check_eq("bcast_data", rd_data_o, 32'hFF33_1234);
    rd_en_i = 1'b1;
    step();
    rd_en_i = 1'b0;

    // Fill to full with one extra packet left pending at the router.
    for (int i = 0; i < DEPTH + 1; i++) rq.push_back(mk_pkt(1'b1));
    drive_router();
    p0 = n_pops;
    for (int i = 0; i < 3 * DEPTH + 12; i++) step();
    check_eq("full_pops", 32'(n_pops - p0), 32'(DEPTH));
    check_eq("full_set", 32'(full_o), 32'd1);
    check_eq("full_17th_waits", 32'(rq.size()), 32'd1);
    rd_en_i = 1'b1;
    step();
    rd_en_i = 1'b0;
    check_eq("read_edge_no_pop", 32'(pop_o), 32'd0);
    step();
    check_eq("pop_after_read", 32'(pop_o), 32'd1);
    step();
    check_eq("refull", 32'(full_o), 32'd1);

    for (int i = 0; i < 300; i++) begin
      if (rq.size() < 3 && $urandom_range(0, 1) == 1) rq.push_back(mk_pkt($urandom_range(0, 2) != 0));
      rd_en_i = ($urandom_range(0, 9) < 6);
      drive_router();
      step();
    end
    rd_en_i = 1'b1;
    for (int i = 0; i < 3 * DEPTH + 20; i++) step();
    check_eq("drained", 32'(empty_o), 32'd1);
    for (int i = 0; i < 3; i++) step();

    rq.push_back(mk_pkt(1'b1));
    rd_en_i = 1'b0;
    drive_router();
    step();
    check_eq("midrst_pop_before", 32'(pop_o), 32'd1);
    rst_i = 1'b0;
    #1;
    check_eq("midrst_pop_drop", 32'(pop_o), 32'd0);
    check_eq("midrst_pkt_cnt", 32'(pkt_cnt_o), 32'd0);
    check_eq("midrst_empty", 32'(empty_o), 32'd1);
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    check_eq("midrst_held_pop", 32'(pop_o), 32'd0);
    rst_i = 1'b1;
    last_pop = cyc - 10;
    for (int i = 0; i < 5; i++) step();
    check_eq("midrst_repop_cnt", 32'(pkt_cnt_o), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
